// File: rtl/fp_share_arb.sv
// fp_share_arb -- arbiter/sequencer that shares one pipelined FP mul/add
// datapath among the three branch inputs of a radix-3 butterfly.
//
// It picks one requester per cycle and drives the operand mux select and
// the common stage-advance enable. A valid/tag pipeline runs alongside the
// datapath, so each result comes out tagged with the branch that issued it.
// When the consumer is not ready and a result is waiting, every stage
// freezes.
//
// Ports
//   CLK       clock, rising edge
//   RST       asynchronous, active-high reset
//   REQ[2:0]  per-branch request; operands held stable while high
//   GNT[2:0]  one-hot grant (combinational); operands sampled on that edge
//   SEL[1:0]  encoded granted index, 0 when there is no grant
//   EN        stage-advance enable for every datapath register
//   OUT_RDY   consumer ready
//   OUT_VAL   result valid at the last stage
//   OUT_TAG   branch index of the presented result
//   INFLIGHT  count of valid pipeline entries, 0..LAT
//
// Parameter LAT (2..8) sets the datapath depth, which is also the fixed
// latency from grant to result.
//
// Build option FP_ARB_RR_EN: when it is defined, a pointer rotates the
// priority (round-robin). When it is undefined, priority is fixed with
// REQ[0] highest and the pointer is tied to 0.
module fp_share_arb #(
  parameter int LAT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] SEL,
  output logic       EN,
  input  logic       OUT_RDY,
  output logic       OUT_VAL,
  output logic [1:0] OUT_TAG,
  output logic [3:0] INFLIGHT
);

  logic [LAT-1:0]      vld_pipe;
  logic [LAT-1:0][1:0] tag_pipe;
  logic                stall, granted, consume;
  logic [1:0]          ptr;
  logic [2:0]          rot;
  logic [1:0]          off;
  logic [2:0]          sum;
  logic [1:0]          idx;
  logic                hit;

  assign OUT_VAL = vld_pipe[LAT-1];
  assign OUT_TAG = tag_pipe[LAT-1];
  assign stall   = OUT_VAL & ~OUT_RDY;
  assign EN      = ~stall;
  assign granted = |GNT;
  assign consume = OUT_VAL & OUT_RDY;

  // Rotate the requests so that the pointer's branch lands at bit 0.
  // rot[k] = REQ[(ptr+k) mod 3].
  always_comb begin
    case (ptr)
      2'd1:    rot = {REQ[0], REQ[2], REQ[1]};
      2'd2:    rot = {REQ[1], REQ[0], REQ[2]};
      default: rot = REQ;
    endcase
  end

  always_comb begin
    hit = 1'b1;
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             hit = 1'b0;
  end

  // Map the offset back to an absolute index: (ptr + off) mod 3.
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];

  always_comb begin
    GNT = '0;
    SEL = '0;
    if (hit && !stall) begin
      SEL = idx;
      GNT = 3'(3'b001 << idx);
    end
  end

`ifdef FP_ARB_RR_EN
  // The granted branch drops to lowest priority for the next grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          ptr <= 2'd0;
    else if (granted) ptr <= (SEL == 2'd2) ? 2'd0 : SEL + 2'd1;
  end
`else
  assign ptr = 2'd0;
`endif

  // Bubbles shift along with data. A stall freezes the whole pipe, so an
  // entry's latency grows by exactly the number of stall cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      INFLIGHT <= '0;
    end else if (EN) begin
      vld_pipe <= {vld_pipe[LAT-2:0], granted};
      tag_pipe <= {tag_pipe[LAT-2:0], SEL};
      if (granted && !consume)      INFLIGHT <= INFLIGHT + 4'd1;
      else if (consume && !granted) INFLIGHT <= INFLIGHT - 4'd1;
    end
  end

endmodule

// File: tb/tb_fp_share_arb.sv
module tb_fp_share_arb;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] REQ;
  logic [2:0] GNT;
  logic [1:0] SEL;
  logic       EN;
  logic       OUT_RDY;
  logic       OUT_VAL;
  logic [1:0] OUT_TAG;
  logic [3:0] INFLIGHT;

  int checks = 0;
  int errors = 0;

  fp_share_arb #(.LAT(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .SEL(SEL), .EN(EN),
    .OUT_RDY(OUT_RDY), .OUT_VAL(OUT_VAL), .OUT_TAG(OUT_TAG), .INFLIGHT(INFLIGHT)
  );

  always #5 CLK = ~CLK;

  // Expected branch index for the k-th grant with REQ=111 held from ptr=0.
  function automatic logic [1:0] fair_idx(input int k);
`ifdef FP_ARB_RR_EN
    return 2'(k % 3);
`else
    return 2'd0;
`endif
  endfunction

  // Expected branch index for the k-th grant with REQ=101 held from ptr=0.
  function automatic logic [1:0] skip_idx(input int k);
`ifdef FP_ARB_RR_EN
    return (k % 2 == 1) ? 2'd2 : 2'd0;
`else
    return 2'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 3'b000; OUT_RDY = 1'b1;
    #2;
    checks++; if (OUT_VAL !== 1'b0) begin errors++; $display("FAIL rst_val got %0h exp 0", OUT_VAL); end
    checks++; if (OUT_TAG !== 2'd0) begin errors++; $display("FAIL rst_tag got %0h exp 0", OUT_TAG); end
    checks++; if (INFLIGHT !== 4'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", INFLIGHT); end
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL rst_en got %0h exp 1", EN); end
    checks++; if (GNT !== 3'b000 || SEL !== 2'd0) begin errors++; $display("FAIL rst_gnt got %b/%0d exp 000/0", GNT, SEL); end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_latency();
    REQ = 3'b010; OUT_RDY = 1'b1;
    #1;
    checks++; if (GNT !== 3'b010 || SEL !== 2'd1) begin errors++; $display("FAIL lat_gnt got %b/%0d exp 010/1", GNT, SEL); end
    tick();
    REQ = 3'b000;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      checks++; if (OUT_VAL !== (cyc == 4)) begin errors++; $display("FAIL lat_val cyc %0d got %0h exp %0h", cyc, OUT_VAL, (cyc == 4)); end
      if (cyc == 4) begin
        checks++; if (OUT_TAG !== 2'd1) begin errors++; $display("FAIL lat_tag got %0d exp 1", OUT_TAG); end
        checks++; if (INFLIGHT !== 4'd1) begin errors++; $display("FAIL lat_inflight got %0d exp 1", INFLIGHT); end
      end
      if (cyc == 5) begin
        checks++; if (INFLIGHT !== 4'd0) begin errors++; $display("FAIL lat_drain got %0d exp 0", INFLIGHT); end
      end
      tick();
    end
  endtask

  // Build three entries, then reset between edges; the entries must vanish.
  task automatic test_midrun_reset();
    logic [2:0] exp_first;
`ifdef FP_ARB_RR_EN
    exp_first = 3'b100;   // ptr was left at 2 by the single grant to branch 1
`else
    exp_first = 3'b001;
`endif
    REQ = 3'b111;
    #1;
    checks++; if (GNT !== exp_first) begin errors++; $display("FAIL mid_gnt got %b exp %b", GNT, exp_first); end
    tick(); tick(); tick();
    REQ = 3'b000;
    checks++; if (INFLIGHT !== 4'd3) begin errors++; $display("FAIL mid_inflight got %0d exp 3", INFLIGHT); end
    RST = 1'b1;
    #1;
    checks++; if (OUT_VAL !== 1'b0 || OUT_TAG !== 2'd0) begin errors++; $display("FAIL mid_rst_out got %0h/%0d exp 0/0", OUT_VAL, OUT_TAG); end
    checks++; if (INFLIGHT !== 4'd0) begin errors++; $display("FAIL mid_rst_inflight got %0d exp 0", INFLIGHT); end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_fairness();
    REQ = 3'b111; OUT_RDY = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      checks++; if (SEL !== fair_idx(k) || GNT !== 3'(3'b001 << fair_idx(k))) begin
        errors++; $display("FAIL fair_gnt k %0d got %b/%0d exp sel %0d", k, GNT, SEL, fair_idx(k)); end
      checks++; if (INFLIGHT !== 4'((k < 4) ? k : 4)) begin
        errors++; $display("FAIL fair_inflight k %0d got %0d exp %0d", k, INFLIGHT, (k < 4) ? k : 4); end
      if (k >= 4) begin
        checks++; if (OUT_VAL !== 1'b1 || OUT_TAG !== fair_idx(k - 4)) begin
          errors++; $display("FAIL fair_out k %0d got %0h/%0d exp 1/%0d", k, OUT_VAL, OUT_TAG, fair_idx(k - 4)); end
      end
      tick();
    end
  endtask

  // Continues from a full pipe left by test_fairness.
  task automatic test_stall();
    REQ = 3'b111; OUT_RDY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (EN !== 1'b0 || GNT !== 3'b000) begin errors++; $display("FAIL stall_en s %0d got %0h/%b exp 0/000", s, EN, GNT); end
      checks++; if (OUT_VAL !== 1'b1 || OUT_TAG !== fair_idx(5) || INFLIGHT !== 4'd4) begin
        errors++; $display("FAIL stall_hold s %0d got %0h/%0d/%0d exp 1/%0d/4", s, OUT_VAL, OUT_TAG, INFLIGHT, fair_idx(5)); end
      tick();
    end
    OUT_RDY = 1'b1;
    #1;
    checks++; if (EN !== 1'b1 || GNT !== 3'b001) begin errors++; $display("FAIL stall_release got %0h/%b exp 1/001", EN, GNT); end
    tick();
    REQ = 3'b000;
    checks++; if (INFLIGHT !== 4'd4 || OUT_TAG !== fair_idx(6)) begin
      errors++; $display("FAIL stall_after got %0d/%0d exp 4/%0d", INFLIGHT, OUT_TAG, fair_idx(6)); end
    for (int d = 0; d < 5; d++) tick();
    checks++; if (INFLIGHT !== 4'd0 || OUT_VAL !== 1'b0) begin errors++; $display("FAIL stall_drain got %0d/%0h exp 0/0", INFLIGHT, OUT_VAL); end
  endtask

  // REQ=101 from ptr=0; OUT_RDY low while the output holds only bubbles.
  task automatic test_skip();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      REQ = (k < 4) ? 3'b101 : 3'b000;
      OUT_RDY = (k >= 4);
      #1;
      if (k < 4) begin
        checks++; if (EN !== 1'b1 || OUT_VAL !== 1'b0) begin errors++; $display("FAIL skip_nostall k %0d got %0h/%0h exp 1/0", k, EN, OUT_VAL); end
        checks++; if (GNT !== 3'(3'b001 << skip_idx(k))) begin errors++; $display("FAIL skip_gnt k %0d got %b exp sel %0d", k, GNT, skip_idx(k)); end
      end else begin
        checks++; if (OUT_VAL !== 1'b1 || OUT_TAG !== skip_idx(k - 4)) begin
          errors++; $display("FAIL skip_out k %0d got %0h/%0d exp 1/%0d", k, OUT_VAL, OUT_TAG, skip_idx(k - 4)); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_midrun_reset();
    test_fairness();
    test_stall();
    test_skip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_share_arb.md
# fp_share_arb

Round-robin arbiter and sequencer sharing one pipelined floating-point multiply/add datapath (the chain of CLK-only stage registers that carries mantissa, exponent, carry and sign fields) among three requesters, the three branch inputs of a radix-3 butterfly. It selects one requester per cycle, drives the operand mux select and a common stage-advance enable, and carries a valid/tag pipeline alongside the datapath so each result leaves tagged with its originating branch. A single global stall freezes all stages when the downstream consumer is not ready.

## Interface
- LAT, 4: datapath depth in register stages, 2..8; fixed latency from grant to result.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- REQ  in  3  per-branch request; the requester holds operands stable while high.
- GNT  out  3  one-hot grant, combinational; operands are sampled into stage 0 on the edge where GNT[i]=1.
- SEL  out  2  encoded index of the granted requester (0..2); 0 when no grant.
- EN  out  1  stage-advance enable for every datapath stage register.
- OUT_RDY  in  1  consumer ready.
- OUT_VAL  out  1  result valid at the last datapath stage.
- OUT_TAG  out  2  requester index of the result presented.
- INFLIGHT  out  4  number of valid entries in the pipeline, 0..LAT.

## Operation
- Internal state: valid shift register v[0..LAT-1], tag shift register t[0..LAT-1] (2 bits each), priority pointer ptr (0..2), counter INFLIGHT.
- Stall: stall = OUT_VAL & ~OUT_RDY. EN = ~stall.
- Arbitration: when stall=1, GNT=0. Otherwise the first i with REQ[i]=1, scanning ptr, ptr+1, ptr+2 (mod 3), is granted. SEL = i. No request -> GNT=0, SEL=0.
- On each edge with EN=1: v[0] <= |GNT, t[0] <= SEL; v[k] <= v[k-1], t[k] <= t[k-1] for k=1..LAT-1. Bubbles advance like data; no bubble collapsing.
- On edge with EN=0: v, t, ptr hold.
- ptr update: on a grant to i, ptr <= (i+1) mod 3; otherwise hold.
- OUT_VAL = v[LAT-1], OUT_TAG = t[LAT-1]; the result is consumed on an edge with OUT_VAL & OUT_RDY.
- INFLIGHT: +1 on grant edge, -1 on consume edge, unchanged when both occur on the same edge. It always equals popcount(v).
- REQ deasserted before grant: nothing is recorded. A requester must not drop REQ in the grant cycle.

## Timing
- Reset (asynchronous): v=0, t=0, ptr=0, INFLIGHT=0, so OUT_VAL=0, OUT_TAG=0. GNT, SEL and EN follow combinationally: EN=1, and GNT resolves from REQ with ptr=0.
- RST asserted mid-operation discards all in-flight entries immediately. No result is emitted for them.
- Latency: a grant on edge n gives OUT_VAL=1 after edge n+LAT-1, i.e. LAT cycles after GNT is seen, with no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one grant per cycle while EN=1. With all three REQ high, grants rotate 0,1,2,0,...
- Stall with pipeline full: EN=0 and GNT=0 until OUT_RDY=1. On the release edge, a new grant is accepted in the same cycle.
- OUT_RDY=0 with OUT_VAL=0: no stall; bubbles at the output are not held.

## Configuration
- FP_ARB_RR_EN defined: round-robin arbitration as above.
- FP_ARB_RR_EN undefined: fixed priority, REQ[0] highest, then REQ[1], then REQ[2]. ptr is removed (held at 0). All other behaviour is identical.

## Test plan
- Reset check: RST pulse mid-run with INFLIGHT=3 -> OUT_VAL=0, INFLIGHT=0, OUT_TAG=0 immediately. The first grant after release goes to REQ[0] when REQ=3'b111.
- Latency check (LAT=4): REQ=3'b010 for one cycle, OUT_RDY=1 -> GNT=3'b010, SEL=1. OUT_VAL=1 with OUT_TAG=1 exactly 4 cycles later, for one cycle.
- Fairness: REQ=3'b111 held for 9 cycles, OUT_RDY=1 -> grant sequence 0,1,2,0,1,2,0,1,2. Outputs appear in the same tag order; INFLIGHT saturates at 4.
- Stall: pipeline full, OUT_RDY=0 for 3 cycles -> EN=0 and GNT=0 for 3 cycles, with OUT_VAL/OUT_TAG and INFLIGHT=4 held. OUT_RDY=1 -> a new grant and a consume on the same edge, INFLIGHT stays 4.
- Skip idle requester: REQ=3'b101 from ptr=0 -> grants 0,2,0,2. ptr never stalls on branch 1.
- Fixed-priority build (FP_ARB_RR_EN undefined): REQ=3'b111 for 4 cycles -> GNT=3'b001 every cycle, and branches 1 and 2 get no grant.
